// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM controller port between the ROM download writer and
// four one-entry-cached game ROM read ports (program, character, tile, sprite).
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    download,
    input  logic [ADDR_WIDTH-1:0]   dl_addr,
    input  logic [DATA_WIDTH-1:0]   dl_data,
    input  logic                    dl_req,
    output logic                    dl_ack,
    input  logic [3:0]              rom_cs,
    input  logic [4*ADDR_WIDTH-1:0] rom_addr,
    output logic [4*DATA_WIDTH-1:0] rom_q,
    output logic [3:0]              rom_valid,
    output logic [ADDR_WIDTH-1:0]   sdram_addr,
    output logic [DATA_WIDTH-1:0]   sdram_data,
    output logic                    sdram_we,
    output logic                    sdram_req,
    input  logic                    sdram_ack,
    input  logic                    sdram_valid,
    input  logic [DATA_WIDTH-1:0]   sdram_q
);
    localparam int NPORT = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_VALID
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              owner_q, owner_d;
    logic [1:0]              last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    req_q, req_d;
    logic                    dl_ack_q, dl_ack_d;
    logic [ADDR_WIDTH-1:0]   tag_addr_q [NPORT];
    logic [ADDR_WIDTH-1:0]   tag_addr_d [NPORT];
    logic [NPORT-1:0]        tag_ok_q, tag_ok_d;
    logic [DATA_WIDTH-1:0]   cache_q [NPORT];
    logic [DATA_WIDTH-1:0]   cache_d [NPORT];

    logic [ADDR_WIDTH-1:0]   port_addr [NPORT];
    logic [NPORT-1:0]        hit;
    logic [NPORT-1:0]        pend;
    logic                    busy;
    logic                    grant_found;
    logic [1:0]              grant_port;
    logic [1:0]              cand;

    assign busy = (state_q != IDLE);

    // The owner of an in-flight read is not pending again until its fill lands.
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign port_addr[gi] = rom_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign hit[gi]       = rom_cs[gi] & tag_ok_q[gi] & (port_addr[gi] == tag_addr_q[gi]);
            assign pend[gi]      = rom_cs[gi] & ~hit[gi] & ~(busy & (owner_q == 2'(gi)));
            assign rom_q[gi*DATA_WIDTH +: DATA_WIDTH] = cache_q[gi];
        end
    endgenerate

    assign rom_valid  = hit;
    assign sdram_addr = addr_q;
    assign sdram_data = wdata_q;
    assign sdram_we   = we_q;
    assign sdram_req  = req_q;
    assign dl_ack     = dl_ack_q;

    // Round-robin search starting just after the most recently granted port.
    always_comb begin
        grant_found = 1'b0;
        grant_port  = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = last_q + 2'(k);
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_port  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        req_d      = req_q;
        dl_ack_d   = 1'b0;
        tag_addr_d = tag_addr_q;
        tag_ok_d   = tag_ok_q;
        cache_d    = cache_q;

        case (state_q)
            IDLE: begin
                if (dl_req) begin
                    addr_d  = dl_addr;
                    wdata_d = dl_data;
                    we_d    = 1'b1;
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else if (!download && grant_found) begin
                    owner_d              = grant_port;
                    last_d               = grant_port;
                    addr_d               = port_addr[grant_port];
                    we_d                 = 1'b0;
                    req_d                = 1'b1;
                    tag_ok_d[grant_port] = 1'b0;
                    state_d              = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        dl_ack_d = 1'b1;
                        state_d  = IDLE;
                    end else if (sdram_valid) begin
                        cache_d[owner_q]    = sdram_q;
                        tag_addr_d[owner_q] = addr_q;
                        tag_ok_d[owner_q]   = 1'b1;
                        state_d             = IDLE;
                    end else begin
                        state_d = WAIT_VALID;
                    end
                end
            end
            WAIT_VALID: begin
                if (sdram_valid) begin
                    cache_d[owner_q]    = sdram_q;
                    tag_addr_d[owner_q] = addr_q;
                    tag_ok_d[owner_q]   = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A download invalidates every cached word, including a fill landing now.
        if (download) begin
            tag_ok_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            dl_ack_q <= 1'b0;
            tag_ok_q <= '0;
            for (int i = 0; i < NPORT; i++) begin
                tag_addr_q[i] <= '0;
                cache_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            req_q    <= req_d;
            dl_ack_q <= dl_ack_d;
            tag_ok_q <= tag_ok_d;
            for (int i = 0; i < NPORT; i++) begin
                tag_addr_q[i] <= tag_addr_d[i];
                cache_q[i]    <= cache_d[i];
            end
        end
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port (addr/data/we/req/ack/valid/q) between the ROM download writer and four game read ports: program ROM, character ROM, tile ROM and sprite ROM. Each read port has a one-entry cache: a fetched word is held and re-served without SDRAM traffic while the port keeps presenting the same address. The block sits between the game ROM fetch logic and the `sdram` controller instance, in the 96 MHz system clock domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 23: SDRAM word-address width.
- `DATA_WIDTH`, 32: SDRAM word width.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `download`  in  1  ROM download in progress; reads are blocked.
- `dl_addr`  in  ADDR_WIDTH  download word address.
- `dl_data`  in  DATA_WIDTH  download write data.
- `dl_req`  in  1  download write request; held until `dl_ack`.
- `dl_ack`  out  1  one-cycle pulse; write accepted by the controller.
- `rom_cs`  in  4  per-port read enable. Bit 0 = program, bit 1 = character, bit 2 = tile, bit 3 = sprite.
- `rom_addr`  in  4*ADDR_WIDTH  per-port address; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rom_q`  out  4*DATA_WIDTH  per-port data, same slicing.
- `rom_valid`  out  4  per port: `rom_q` is valid for the current `rom_addr`.
- `sdram_addr`  out  ADDR_WIDTH  controller address.
- `sdram_data`  out  DATA_WIDTH  controller write data.
- `sdram_we`  out  1  controller write enable.
- `sdram_req`  out  1  controller request.
- `sdram_ack`  in  1  controller command accepted.
- `sdram_valid`  in  1  controller read data valid.
- `sdram_q`  in  DATA_WIDTH  controller read data.

## Operation
- **Per-port state (i = 0..3):**
  - `tag_addr[i]` (ADDR_WIDTH), `tag_ok[i]`, `data[i]` (DATA_WIDTH).
  - `hit[i] = rom_cs[i] & tag_ok[i] & (rom_addr[i] == tag_addr[i])`.
  - `rom_valid[i] = hit[i]` (combinational); `rom_q[i] = data[i]`.
  - `pend[i] = rom_cs[i] & ~hit[i] & ~(busy & owner == i)`.
- **States:**
  - `IDLE`: no transaction in flight.
  - `WAIT_ACK`: `sdram_req` asserted, waiting for acceptance.
  - `WAIT_VALID`: read accepted, waiting for data.
- **Grant in IDLE, evaluated each cycle:**
  - `dl_req` has highest priority. Latch `dl_addr`/`dl_data`, set `sdram_we = 1`, go to WAIT_ACK.
  - Otherwise, if `~download` and any `pend[i]`: round-robin grant, searching from `last + 1` mod 4 upward, where `last` is the most recently granted read port. Set `owner = i` and `last = i`, latch `rom_addr[i]`, `sdram_we = 0`, clear `tag_ok[i]`, go to WAIT_ACK.
- **WAIT_ACK:** `sdram_req = 1` with addr/data/we held stable. On `sdram_ack`:
  - Write: pulse `dl_ack`, return to IDLE.
  - Read: go to WAIT_VALID.
- **WAIT_VALID:** on `sdram_valid`:
  - `data[owner] <= sdram_q`.
  - `tag_addr[owner] <=` latched address.
  - `tag_ok[owner] <= 1`.
  - Return to IDLE.
- **Address change mid-flight:** completion still fills the tag with the latched address. The hit compare then fails and the port requests again.
- **Download:**
  - While `download = 1`, all `tag_ok` are held cleared.
  - Any in-flight read completes normally, but its fill is discarded (`tag_ok` stays 0).
- **Reset:** asserting `reset_n = 0` at any time, including mid-transaction, forces IDLE immediately. The SDRAM controller is reset by the same source and has no pending command to drain.

## Timing
- **Reset values:** `sdram_req = 0`, `sdram_we = 0`, `sdram_addr = 0`, `sdram_data = 0`, `dl_ack = 0`, all `tag_ok = 0`, `data = 0`, `last = 3` (so port 0 wins first), state IDLE.
- **Request assertion:** `sdram_req` is registered and rises on the clock edge after the grant. It falls on the edge after `sdram_ack` is sampled high and is never high in IDLE.
- **Write acknowledge:** `dl_ack` is registered, high for exactly one cycle, on the edge after `sdram_ack`. The requester must drop or change `dl_req` in the `dl_ack` cycle, or a second write is issued.
- **Read miss latency:** `rom_valid` rises 1 cycle after `sdram_valid`. Counted from `rom_cs`, that is 1 (grant) + controller ack latency + controller valid latency + 1.
- **Back-to-back:** a new grant may be made in the IDLE cycle that immediately follows a completion. There are no dead cycles beyond that.
- **Hit latency:** 0 cycles; `rom_valid` is combinational from `rom_cs`/`rom_addr`.
- **Simultaneous `sdram_ack` and `sdram_valid`:** in WAIT_ACK, a read takes `sdram_ack` and the fill on the same edge.

## Test plan
- **Reset:** `reset_n` low for 3 cycles → all outputs 0. First request on port 2 (addr 0x100) → `sdram_req` 1 cycle later with `sdram_addr = 0x100`, `sdram_we = 0`.
- **Miss then hit:** port 0 reads 0x1234 and the controller returns 0xDEADBEEF → `rom_valid[0] = 1`, `rom_q[0] = 0xDEADBEEF`. Hold the same address for 20 cycles → no further `sdram_req`.
- **Round robin:** all four ports miss simultaneously, then each re-misses on a new address after its fill → grant order 0,1,2,3,0. No port is granted twice before the others.
- **Download priority:** `dl_req` and `rom_cs[1]` rise in the same cycle with `download = 1` → the write is granted first with `sdram_we = 1` and `dl_ack` pulses once. Port 1 is not granted until `download = 0`, and all `tag_ok` are cleared.
- **Address change mid-flight:** port 3 requests 0x10, changes to 0x20 before `sdram_valid` → `rom_valid[3]` stays 0 after the first fill, a second read of 0x20 is issued, and `rom_valid[3] = 1` afterwards.
- **Reset mid-transaction:** `reset_n` low while in WAIT_VALID → `sdram_req = 0` and `tag_ok = 0` immediately. After release, a late `sdram_valid` pulse does not set any `rom_valid`.
